// File: rtl/rcswitch_receive_pkg.sv
// Shared constants and types for the RC-switch tri-state frame receiver.
package rcswitch_receive_pkg;
  localparam logic [3:0] CHIP_ZERO   = 4'b1000;
  localparam logic [3:0] CHIP_ONE    = 4'b1110;
  localparam int         FRAME_BITS  = 24;
  localparam int         FRAME_CHIPS = 96;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  typedef enum logic [1:0] {PC_SHORT, PC_LONG, PC_INVALID} pclass_t;

  function automatic logic [3:0] chips_of(input logic one);
    return one ? CHIP_ONE : CHIP_ZERO;
  endfunction
endpackage

// File: rtl/rcswitch_receive_pulse_class.sv
// Classifies a measured pulse width against the chip time: SHORT [C/2,2C), LONG [2C,4C), else INVALID.
module rcswitch_pulse_class
  import rcswitch_receive_pkg::*;
#(
  parameter int CHIP_TICKS = 350,
  parameter int W          = 12
) (
  input  logic [W-1:0] width,
  output pclass_t      cls
);
  localparam logic [W-1:0] T_HALF = W'(CHIP_TICKS / 2);
  localparam logic [W-1:0] T_2C   = W'(2 * CHIP_TICKS);
  localparam logic [W-1:0] T_4C   = W'(4 * CHIP_TICKS);

  always_comb begin
    cls = PC_INVALID;
    if (width >= T_HALF && width < T_2C)     cls = PC_SHORT;
    else if (width >= T_2C && width < T_4C) cls = PC_LONG;
  end
endmodule

// File: rtl/rcswitch_receive.sv
// RC-switch tri-state frame decoder: measures pulse widths on the RF line and rebuilds addr/chan/stat.
// Optional RCSWITCH_RECV_REPEAT_EN: strobe only when two consecutive completed frames match.
module rcswitch_receive
  import rcswitch_receive_pkg::*;
#(
  parameter int CHIP_TICKS = 350,
  parameter int SYNC_CHIPS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in,
  output logic [39:0] addr,
  output logic [39:0] chan,
  output logic [15:0] stat,
  output logic        valid,
  output logic        busy
);
  localparam int WW = $clog2(8 * CHIP_TICKS + 1);
  localparam int GW = $clog2(SYNC_CHIPS * CHIP_TICKS + 1);
  localparam logic [WW-1:0] W_SAT    = WW'(8 * CHIP_TICKS);
  localparam logic [WW-1:0] W_HMAX   = WW'(4 * CHIP_TICKS);
  localparam logic [WW-1:0] W_HALF   = WW'(CHIP_TICKS / 2);
  localparam logic [GW-1:0] G_SAT    = GW'(SYNC_CHIPS * CHIP_TICKS);
  localparam logic [GW-1:0] G_ARM    = GW'(SYNC_CHIPS * CHIP_TICKS - 1);
  localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS - 1);

  logic                   s1, s2, prev;
  logic                   line, rise, fall;
  logic [WW-1:0]          width;
  logic [GW-1:0]          gap;
  logic                   armed, arm_set;
  state_t                 state, state_nxt;
  logic [4:0]             bit_idx, bit_idx_nxt;
  logic                   one, one_nxt;
  logic                   shift_en, done_en, strobe;
  logic [FRAME_CHIPS-5:0] sr;
  logic [FRAME_CHIPS-1:0] frame_nxt;
  pclass_t                cls;

  assign line = s2;
  assign rise = line & ~prev;
  assign fall = ~line & prev;
  assign busy = (state == HIGH) || (state == LOW);
  // Arming fires on the cycle the gap reaches its full length, so a rise right after is already armed.
  assign arm_set   = ~line && (gap >= G_ARM);
  assign frame_nxt = {sr, chips_of(one)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= in;
      s2   <= s1;
      prev <= s2;
    end
  end

  // width holds the length of the level in force up to the previous cycle; restarts at every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width <= '0;
      gap   <= '0;
      armed <= 1'b0;
    end else begin
      if (rise || fall)      width <= WW'(1);
      else if (width != W_SAT) width <= width + WW'(1);
      if (line)              gap <= '0;
      else if (gap != G_SAT) gap <= gap + GW'(1);
      if (rise)              armed <= 1'b0;
      else if (arm_set)      armed <= 1'b1;
    end
  end

  rcswitch_pulse_class #(.CHIP_TICKS(CHIP_TICKS), .W(WW)) u_class (
    .width (width),
    .cls   (cls)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      one     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      one     <= one_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    one_nxt     = one;
    shift_en    = 1'b0;
    done_en     = 1'b0;
    case (state)
      IDLE: if (rise && armed) begin
        state_nxt   = HIGH;
        bit_idx_nxt = '0;
      end
      HIGH: begin
        if (fall) begin
          case (cls)
            PC_SHORT: begin one_nxt = 1'b0; state_nxt = LOW; end
            PC_LONG:  begin one_nxt = 1'b1; state_nxt = LOW; end
            default:  state_nxt = IDLE;
          endcase
        end else if (width >= W_HMAX) begin
          state_nxt = IDLE;
        end
      end
      LOW: begin
        if (bit_idx == LAST_BIT) begin
          // The sync gap follows the last bit, so accept as soon as the low is long enough.
          if (rise) state_nxt = IDLE;
          else if (width >= W_HALF) begin
            done_en   = 1'b1;
            state_nxt = DONE;
          end
        end else if (rise) begin
          if (cls == (one ? PC_SHORT : PC_LONG)) begin
            shift_en    = 1'b1;
            bit_idx_nxt = bit_idx + 5'd1;
            state_nxt   = HIGH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (arm_set && busy && !done_en) state_nxt = IDLE;
  end

`ifdef RCSWITCH_RECV_REPEAT_EN
  logic [FRAME_CHIPS-1:0] last_frame;
  logic                   last_vld, strobed, same;

  assign same   = last_vld && (frame_nxt == last_frame);
  assign strobe = same && !strobed;

  // strobed stays set across a run of identical frames so only the first repeat strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_frame <= '0;
      last_vld   <= 1'b0;
      strobed    <= 1'b0;
    end else if (done_en) begin
      last_frame <= frame_nxt;
      last_vld   <= 1'b1;
      strobed    <= same;
    end
  end
`else
  assign strobe = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr    <= '0;
      addr  <= '0;
      chan  <= '0;
      stat  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (shift_en) sr <= frame_nxt[FRAME_CHIPS-5:0];
      if (done_en && strobe) begin
        {addr, chan, stat} <= frame_nxt;
        valid              <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rcswitch_receive.sv
// Directed bench for rcswitch_receive with CHIP_TICKS=4, SYNC_CHIPS=10; the bench plays the transmitter.
`timescale 1ns/1ps
module tb_rcswitch_receive;
  localparam int C = 4;
  localparam logic [23:0] FA = 24'h000554;
  localparam logic [23:0] FC = 24'hFFFFFF;
  localparam logic [23:0] FD = 24'h800001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_r = 1'b0;
  logic [39:0] addr, chan;
  logic [15:0] stat;
  logic        valid, busy;

  int ntot = 0, nbad = 0;
  int cyc = 0, nval = 0, t_valid = 0, edge_cyc = 0, fall_cyc = 0, n0 = 0;

  rcswitch_receive #(.CHIP_TICKS(C), .SYNC_CHIPS(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_r),
    .addr  (addr),
    .chan  (chan),
    .stat  (stat),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid) begin
    nval++;
    t_valid = cyc;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lv, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) edge_cyc = cyc;
      in_r = lv;
    end
  endtask

  // Bits go out first-received first (f[23]); bit 1 = 3C high + C low, bit 0 = C high + 3C low.
  task automatic send_bits(input logic [23:0] f, input int nbits, input int stretch, input int glitch);
    logic one;
    for (int b = 0; b < nbits; b++) begin
      one = f[23-b];
      drive(1'b1, (b == stretch) ? 17 : (one ? 3*C : C));
      if (b == glitch) begin
        drive(1'b0, 5); drive(1'b1, 1); drive(1'b0, 6);
      end else begin
        drive(1'b0, one ? C : 3*C);
        fall_cyc = edge_cyc;
      end
    end
  endtask

  task automatic send_good(input logic [23:0] f);
`ifdef RCSWITCH_RECV_REPEAT_EN
    drive(1'b0, 48);
    send_bits(f, 24, -1, -1);
`endif
    drive(1'b0, 48);
    send_bits(f, 24, -1, -1);
    drive(1'b0, 8);
    #1;
  endtask

  initial begin
    #2 rst = 1'b0;
    drive(1'b0, 3);
    #1;
    chk("reset_addr", addr, 40'h0);
    chk("reset_chan", chan, 40'h0);
    chk("reset_stat", stat, 16'h0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    @(negedge clk) rst = 1'b1;

    // 1: basic frame
    n0 = nval;
    send_good(FA);
    chk("t1_count", nval - n0, 1);
    chk("t1_addr", addr, 40'h8888888888);
    chk("t1_chan", chan, 40'h888E8E8E8E);
    chk("t1_stat", stat, 16'h8E88);
    chk("t1_latency", 64'(t_valid - fall_cyc), 64'd5);
    chk("t1_busy_idle", busy, 1'b0);

    // 2: reset in the middle of bit 10
    drive(1'b0, 48);
    send_bits(FA, 10, -1, -1);
    drive(1'b1, 4);
    #1;
    chk("t2_busy_mid", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("t2_rst_addr", addr, 40'h0);
    chk("t2_rst_chan", chan, 40'h0);
    chk("t2_rst_stat", stat, 16'h0);
    chk("t2_rst_busy", busy, 1'b0);
    chk("t2_rst_valid", valid, 1'b0);
    in_r = 1'b0;
    drive(1'b0, 3);
    @(negedge clk) rst = 1'b1;
    n0 = nval;
    send_good(FA);
    chk("t2_count", nval - n0, 1);
    chk("t2_addr", addr, 40'h8888888888);

    // 3: stretched high pulse aborts, outputs held, next frame decodes
    n0 = nval;
    drive(1'b0, 48);
    send_bits(FA, 24, 5, -1);
    drive(1'b0, 20);
    #1;
    chk("t3_abort_count", nval - n0, 0);
    chk("t3_held_addr", addr, 40'h8888888888);
    n0 = nval;
    send_good(FC);
    chk("t3_count", nval - n0, 1);
    chk("t3_addr", addr, 40'hEEEEEEEEEE);
    chk("t3_chan", chan, 40'hEEEEEEEEEE);
    chk("t3_stat", stat, 16'hEEEE);

    // 4: 1-tick glitch in a low phase
    n0 = nval;
    drive(1'b0, 48);
    send_bits(FA, 24, -1, 2);
    drive(1'b0, 20);
    #1;
    chk("t4_count", nval - n0, 0);
    chk("t4_held_addr", addr, 40'hEEEEEEEEEE);

    // 5: 39-tick gap does not arm, 40-tick gap does
`ifdef RCSWITCH_RECV_REPEAT_EN
    drive(1'b0, 48);
    send_bits(FD, 24, -1, -1);
    drive(1'b0, 48);
`endif
    n0 = nval;
    drive(1'b1, 4);
    drive(1'b0, 39);
    send_bits(FD, 24, -1, -1);
    drive(1'b0, 20);
    #1;
    chk("t5_gap39_count", nval - n0, 0);
    chk("t5_gap39_addr", addr, 40'hEEEEEEEEEE);
    n0 = nval;
    drive(1'b1, 4);
    drive(1'b0, 40);
    send_bits(FD, 24, -1, -1);
    drive(1'b0, 8);
    #1;
    chk("t5_gap40_count", nval - n0, 1);
    chk("t5_addr", addr, 40'hE888888888);
    chk("t5_chan", chan, 40'h8888888888);
    chk("t5_stat", stat, 16'h888E);

    // 6: A, A, A, B, B
    n0 = nval;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 48);
      send_bits((k < 3) ? FA : FC, 24, -1, -1);
      drive(1'b0, 8);
    end
    #1;
`ifdef RCSWITCH_RECV_REPEAT_EN
    chk("t6_count", nval - n0, 2);
`else
    chk("t6_count", nval - n0, 5);
`endif
    chk("t6_addr", addr, 40'hEEEEEEEEEE);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end
endmodule
